// File: rtl/signed_div_pkg.sv
// Shared types and defaults for the signed divider front end and the divider.
package signed_div_pkg;

    localparam int SD_DATA_W = 8;
    localparam int SD_FRAC_W = 4;
    localparam int SD_ERR_W  = 4;

    localparam logic [SD_ERR_W-1:0] SD_ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_DIVIDEND = 2'd0,
        S_DIVISOR  = 2'd1,
        S_OUT      = 2'd2
    } frame_state_e;

endpackage

// File: rtl/signed_mag.sv
// Two's-complement to sign + magnitude; the most-negative input maps onto itself as unsigned.
module signed_mag
    import signed_div_pkg::*;
#(
    parameter int DATA_W = SD_DATA_W
) (
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_mag,
    output logic              o_sign,
    output logic              o_zero
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    always_comb begin
        o_sign = i_x[DATA_W-1];
        o_zero = (i_x == '0);
        o_mag  = o_sign ? (~i_x + ONE) : i_x;
    end

endmodule

// File: rtl/signed_div_operand_framer.sv
// Frames a dividend/divisor byte pair into sign+magnitude operands for an unsigned divider.
//
// state      | meaning
// S_DIVIDEND | waiting for a byte flagged first (dividend)
// S_DIVISOR  | dividend held, waiting for the divisor byte
// S_OUT      | operand pair presented, waiting for the divider
module signed_div_operand_framer
    import signed_div_pkg::*;
#(
    parameter int DATA_W = SD_DATA_W,
    parameter int FRAC_W = SD_FRAC_W
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_valid,
    input  logic                i_first,
    output logic                o_ready,
    output logic [DATA_W-1:0]   o_dividend_mag,
    output logic [DATA_W-1:0]   o_divisor_mag,
    output logic                o_neg,
    output logic                o_div_by_zero,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SD_ERR_W-1:0] o_err_count
);

    localparam logic [SD_ERR_W-1:0] ERR_ONE = SD_ERR_W'(1);

    // FRAC_W only labels the fixed-point format; reject nonsensical values early.
    if (FRAC_W < 0 || FRAC_W > DATA_W) begin : g_frac_check
        $error("FRAC_W must lie within 0..DATA_W");
    end

    frame_state_e state_q, state_d;

    logic [DATA_W-1:0]   dividend_raw_q, dividend_raw_d;
    logic [DATA_W-1:0]   dividend_mag_q, dividend_mag_d;
    logic [DATA_W-1:0]   divisor_mag_q,  divisor_mag_d;
    logic                neg_q,          neg_d;
    logic                div_by_zero_q,  div_by_zero_d;
    logic [SD_ERR_W-1:0] err_count_q,    err_count_d;

    logic                accept;
    logic                err_inc;

    logic [DATA_W-1:0]   dvd_mag, dvs_mag;
    logic                dvd_sign, dvs_sign;
    logic                dvd_zero, dvs_zero;

    signed_mag #(.DATA_W(DATA_W)) u_dividend_mag (
        .i_x    (dividend_raw_q),
        .o_mag  (dvd_mag),
        .o_sign (dvd_sign),
        .o_zero (dvd_zero)
    );

    // The divisor is converted straight off the input so the pair is ready one edge after it arrives.
    signed_mag #(.DATA_W(DATA_W)) u_divisor_mag (
        .i_x    (i_data),
        .o_mag  (dvs_mag),
        .o_sign (dvs_sign),
        .o_zero (dvs_zero)
    );

    assign accept = i_valid && o_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_DIVIDEND;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DIVIDEND: if (accept && i_first)  state_d = S_DIVISOR;
            S_DIVISOR:  if (accept && !i_first) state_d = S_OUT;
            S_OUT:      if (i_ready)            state_d = S_DIVIDEND;
            default:                            state_d = S_DIVIDEND;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        o_ready = (state_q != S_OUT);
        o_valid = (state_q == S_OUT);
    end

    always_comb begin
        dividend_raw_d = dividend_raw_q;
        dividend_mag_d = dividend_mag_q;
        divisor_mag_d  = divisor_mag_q;
        neg_d          = neg_q;
        div_by_zero_d  = div_by_zero_q;
        err_count_d    = err_count_q;
        err_inc        = 1'b0;

        if (accept) begin
            case (state_q)
                S_DIVIDEND: begin
                    if (i_first) dividend_raw_d = i_data;
                    else         err_inc        = 1'b1;
                end
                S_DIVISOR: begin
                    if (i_first) begin
                        dividend_raw_d = i_data;
                        err_inc        = 1'b1;
                    end else begin
                        dividend_mag_d = dvd_mag;
                        divisor_mag_d  = dvs_mag;
                        div_by_zero_d  = dvs_zero;
                        // A zero dividend gives a zero quotient, which is never negative.
                        if (dvd_zero)      neg_d = 1'b0;
                        else if (dvs_zero) neg_d = dvd_sign;
                        else               neg_d = dvd_sign ^ dvs_sign;
                    end
                end
                default: ;
            endcase
        end

        if (err_inc && (err_count_q != SD_ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            dividend_raw_q <= '0;
            dividend_mag_q <= '0;
            divisor_mag_q  <= '0;
            neg_q          <= 1'b0;
            div_by_zero_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            dividend_raw_q <= dividend_raw_d;
            dividend_mag_q <= dividend_mag_d;
            divisor_mag_q  <= divisor_mag_d;
            neg_q          <= neg_d;
            div_by_zero_q  <= div_by_zero_d;
            err_count_q    <= err_count_d;
        end
    end

    assign o_dividend_mag = dividend_mag_q;
    assign o_divisor_mag  = divisor_mag_q;
    assign o_neg          = neg_q;
    assign o_div_by_zero  = div_by_zero_q;
    assign o_err_count    = err_count_q;

    a_valid_only_in_out: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_valid |-> (state_q == S_OUT));

    a_hold_while_stalled: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (o_valid && !i_ready) |=> $stable({o_dividend_mag, o_divisor_mag, o_neg,
                                           o_div_by_zero, o_valid, o_err_count}));

    a_err_count_monotonic: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        1'b1 |=> (o_err_count >= $past(o_err_count)));

endmodule
